// File: rtl/return_stack.sv
// return_stack: call/return address stack with interrupt-frame tracking and sticky overflow/underflow flags.
module return_stack #(
    parameter int DEPTH = 16,
    parameter int AW = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          Push,
    input  logic          IntPush,
    input  logic          Pop,
    input  logic [AW-1:0] DiST,
    input  logic          ClrErr,
    output logic [AW-1:0] DoST,
    output logic          TopIsInt,
    output logic          Empty,
    output logic          Full,
    output logic [LW-1:0] Level,
    output logic [LW-1:0] IntDepth,
    output logic          InISR,
    output logic          Ovf,
    output logic          Udf
);
    logic [AW:0]   mem [DEPTH];
    logic [LW-1:0] level, int_depth;
    logic          ovf, udf;
    logic [PW-1:0] top_idx, wr_idx;
    logic [AW:0]   top;
    logic          eff_push, replace, do_push, do_pop, wr_en, inc, dec, ovf_ev, udf_ev;

    assign Empty    = level == '0;
    assign Full     = level == LW'(DEPTH);
    assign top_idx  = level[PW-1:0] - PW'(1);
    assign top      = mem[top_idx];
    assign DoST     = Empty ? '0 : top[AW-1:0];
    assign TopIsInt = !Empty && top[AW];
    assign eff_push = Push | IntPush;
    // push+pop on a non-empty stack rewrites the top in place, so it never overflows
    assign replace  = eff_push && Pop && !Empty;
    assign do_push  = eff_push && (Pop ? Empty : !Full);
    assign do_pop   = Pop && !eff_push && !Empty;
    assign ovf_ev   = eff_push && !Pop && Full;
    assign udf_ev   = Pop && Empty;
    assign wr_en    = do_push || replace;
    assign wr_idx   = replace ? top_idx : level[PW-1:0];
    assign inc      = wr_en && IntPush;
    assign dec      = (do_pop || replace) && top[AW];
    assign Level    = level;
    assign IntDepth = int_depth;
    assign InISR    = int_depth != '0;
    assign Ovf      = ovf;
    assign Udf      = udf;

    always_ff @(posedge CLK)
        if (wr_en) mem[wr_idx] <= {IntPush, DiST};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            level     <= '0;
            int_depth <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            level     <= level + LW'(do_push) - LW'(do_pop);
            int_depth <= int_depth + LW'(inc) - LW'(dec);
            ovf       <= ovf_ev || (ovf && !ClrErr);
            udf       <= udf_ev || (udf && !ClrErr);
        end
    end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed plan plus random traffic, checked every cycle against a queue-based model.
module tb_return_stack;
    localparam int DEPTH = 16;
    localparam int AW = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          CLK = 0;
    logic          RSTn = 0;
    logic          Push = 0, IntPush = 0, Pop = 0, ClrErr = 0;
    logic [AW-1:0] DiST = '0;
    logic [AW-1:0] DoST;
    logic          TopIsInt, Empty, Full, InISR, Ovf, Udf;
    logic [LW-1:0] Level, IntDepth;

    int n_chk = 0;
    int n_fail = 0;

    return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RSTn(RSTn), .Push(Push), .IntPush(IntPush), .Pop(Pop),
        .DiST(DiST), .ClrErr(ClrErr), .DoST(DoST), .TopIsInt(TopIsInt),
        .Empty(Empty), .Full(Full), .Level(Level), .IntDepth(IntDepth),
        .InISR(InISR), .Ovf(Ovf), .Udf(Udf)
    );

    always #5 CLK = ~CLK;

    // model: a queue of {tag, addr} frames, back = top
    logic [AW:0] stk[$];
    bit m_ovf, m_udf;

    function automatic int m_int_depth();
        int n = 0;
        foreach (stk[i]) n += int'(stk[i][AW]);
        return n;
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stk.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            bit ep, oe, ue;
            ep = Push | IntPush;
            oe = 0;
            ue = 0;
            if (Pop && stk.size() == 0) ue = 1;
            if (ep && Pop && stk.size() != 0) stk[stk.size()-1] = {IntPush, DiST};
            else if (ep && !Pop && stk.size() == DEPTH) oe = 1;
            else if (ep) stk.push_back({IntPush, DiST});
            else if (Pop && stk.size() != 0) void'(stk.pop_back());
            m_ovf = oe || (m_ovf && !ClrErr);
            m_udf = ue || (m_udf && !ClrErr);
        end
    end

    task automatic chk(string nm, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn) begin
            int sz, id;
            sz = stk.size();
            id = m_int_depth();
            chk("cmp.Level", int'(Level), sz);
            chk("cmp.IntDepth", int'(IntDepth), id);
            chk("cmp.DoST", int'(DoST), sz == 0 ? 0 : int'(stk[sz-1][AW-1:0]));
            chk("cmp.TopIsInt", int'(TopIsInt), sz == 0 ? 0 : int'(stk[sz-1][AW]));
            chk("cmp.Empty", int'(Empty), int'(sz == 0));
            chk("cmp.Full", int'(Full), int'(sz == DEPTH));
            chk("cmp.InISR", int'(InISR), int'(id != 0));
            chk("cmp.Ovf", int'(Ovf), int'(m_ovf));
            chk("cmp.Udf", int'(Udf), int'(m_udf));
        end
    end

    task automatic set(bit p, bit ip, bit po, logic [AW-1:0] d, bit c);
        Push = p; IntPush = ip; Pop = po; DiST = d; ClrErr = c;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        set(0, 0, 0, '0, 0);
    endtask

    task automatic step(bit p, bit ip, bit po, logic [AW-1:0] d, bit c);
        set(p, ip, po, d, c);
        tick();
    endtask

    initial begin
        #12;
        chk("rst.Level", int'(Level), 0);
        chk("rst.Empty", int'(Empty), 1);
        chk("rst.DoST", int'(DoST), 0);
        chk("rst.Full", int'(Full), 0);
        RSTn = 1;
        tick();
        // 1: basic LIFO
        step(1, 0, 0, 16'h0010, 0);
        step(1, 0, 0, 16'h0020, 0);
        step(1, 0, 0, 16'h0030, 0);
        chk("t1.Level", int'(Level), 3);
        chk("t1.DoST", int'(DoST), 16'h0030);
        step(0, 0, 1, 0, 0);
        chk("t1.pop1", int'(DoST), 16'h0020);
        step(0, 0, 1, 0, 0);
        chk("t1.pop2", int'(DoST), 16'h0010);
        step(0, 0, 1, 0, 0);
        chk("t1.pop3", int'(DoST), 0);
        chk("t1.Empty", int'(Empty), 1);
        // 2: interrupt frame
        step(1, 0, 0, 16'h0100, 0);
        step(0, 1, 0, 16'h0200, 0);
        chk("t2.TopIsInt", int'(TopIsInt), 1);
        chk("t2.IntDepth", int'(IntDepth), 1);
        chk("t2.InISR", int'(InISR), 1);
        set(0, 0, 1, 0, 0);
        #1;
        chk("t2.DoST_in_pop", int'(DoST), 16'h0200);
        tick();
        chk("t2.IntDepth_after", int'(IntDepth), 0);
        chk("t2.InISR_after", int'(InISR), 0);
        chk("t2.DoST_after", int'(DoST), 16'h0100);
        step(0, 0, 1, 0, 0);
        // 3: full, overflow, replace when full, clear
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, AW'(16'h1000 + i), 0);
        chk("t3.Full", int'(Full), 1);
        step(1, 0, 0, 16'h2222, 0);
        chk("t3.Ovf", int'(Ovf), 1);
        chk("t3.DoST_refused", int'(DoST), 16'h100F);
        chk("t3.Level_refused", int'(Level), DEPTH);
        step(1, 0, 1, 16'hBEEF, 0);
        chk("t3.Level_repl", int'(Level), DEPTH);
        chk("t3.DoST_repl", int'(DoST), 16'hBEEF);
        step(0, 0, 0, 0, 1);
        chk("t3.Ovf_clr", int'(Ovf), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
        // 4: underflow
        step(0, 0, 1, 0, 0);
        chk("t4.Udf", int'(Udf), 1);
        chk("t4.Level", int'(Level), 0);
        chk("t4.DoST", int'(DoST), 0);
        step(1, 0, 1, 16'h0042, 0);
        chk("t4.Level_pp", int'(Level), 1);
        chk("t4.DoST_pp", int'(DoST), 16'h0042);
        chk("t4.Udf_pp", int'(Udf), 1);
        step(0, 0, 1, 0, 1);
        chk("t4.Udf_clr", int'(Udf), 0);
        // 5: Push and IntPush together
        step(1, 1, 0, 16'h0055, 0);
        chk("t5.TopIsInt", int'(TopIsInt), 1);
        chk("t5.Level", int'(Level), 1);
        chk("t5.IntDepth", int'(IntDepth), 1);
        // 6: asynchronous reset mid-operation
        step(1, 0, 0, 16'h0066, 0);
        step(0, 1, 0, 16'h0077, 0);
        step(1, 0, 0, 16'h0088, 0);
        step(1, 0, 0, 16'h0099, 0);
        chk("t6.Level_pre", int'(Level), 5);
        chk("t6.IntDepth_pre", int'(IntDepth), 2);
        #1;
        RSTn = 0;
        #1;
        chk("t6.Level", int'(Level), 0);
        chk("t6.IntDepth", int'(IntDepth), 0);
        chk("t6.Empty", int'(Empty), 1);
        chk("t6.DoST", int'(DoST), 0);
        chk("t6.InISR", int'(InISR), 0);
        chk("t6.TopIsInt", int'(TopIsInt), 0);
        #1;
        RSTn = 1;
        tick();
        // random traffic in push-heavy and pop-heavy phases to reach both boundaries
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                int r;
                bit p, ip, po;
                r = $urandom_range(0, 99);
                p  = (ph % 2 == 0) ? r < 60 : r < 20;
                ip = $urandom_range(0, 3) == 0;
                po = (ph % 2 == 0) ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
                step(p, ip, po, AW'($urandom), $urandom_range(0, 9) == 0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
